// File: rtl/serial_subtractor.sv
// Bit-serial 32-bit subtractor: one bit per cycle, LSB first, result loaded at DONE.
// Define SERIAL_SUB_FLAGS_EN to add the zero and signed-overflow flag outputs.
module serial_subtractor (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] diff,
    output logic        borrow_out
`ifdef SERIAL_SUB_FLAGS_EN
   ,output logic        zero,
    output logic        overflow
`endif
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | shifting one bit per cycle, 32 cycles
    // DONE  | result registers just loaded, done pulse
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] a_sr, b_sr, res_sr;
    logic [4:0]  cnt;
    logic        bw;
    logic        d, bw_nxt, accept, last;
    logic [31:0] res_nxt;
`ifdef SERIAL_SUB_FLAGS_EN
    logic        a_msb, b_msb;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == 5'd31) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        d       = a_sr[0] ^ b_sr[0] ^ bw;
        bw_nxt  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bw);
        res_nxt = {d, res_sr[31:1]};
        last    = (state == RUN) && (cnt == 5'd31);
    end

    // The final bit is folded in combinationally so outputs load on the DONE entry edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cnt        <= '0;
            bw         <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
`endif
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            cnt    <= '0;
            bw     <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb  <= a[31];
            b_msb  <= b[31];
`endif
        end else if (state == RUN) begin
            a_sr   <= {1'b0, a_sr[31:1]};
            b_sr   <= {1'b0, b_sr[31:1]};
            res_sr <= res_nxt;
            cnt    <= cnt + 5'd1;
            bw     <= bw_nxt;
            if (last) begin
                diff       <= res_nxt;
                borrow_out <= bw_nxt;
`ifdef SERIAL_SUB_FLAGS_EN
                zero       <= (res_nxt == 32'd0);
                overflow   <= (a_msb != b_msb) && (d != a_msb);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: latency/arithmetic reference model plus directed literal checks.
// Covers the SERIAL_SUB_FLAGS_EN flag outputs when that macro is defined.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, borrow_out;
    logic [31:0] diff;
`ifdef SERIAL_SUB_FLAGS_EN
    logic        zero, overflow;
`endif

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    serial_subtractor dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_FLAGS_EN
       ,.zero(zero), .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: operation takes 32 cycles after acceptance, then results appear.
    logic        m_busy = 1'b0, m_done = 1'b0, m_bor = 1'b0, m_zero = 1'b0, m_ovf = 1'b0;
    logic [31:0] m_diff = '0, pa = '0, pb = '0;
    int          rem = 0;

    always @(posedge clk) begin
        logic [31:0] r;
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_diff <= '0; m_bor <= 1'b0;
            m_zero <= 1'b0; m_ovf <= 1'b0; rem <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy && start) begin
                m_busy <= 1'b1;
                rem    <= 32;
                pa     <= a;
                pb     <= b;
            end else if (m_busy) begin
                if (rem == 1) begin
                    r       = pa - pb;
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_diff <= r;
                    m_bor  <= (pa < pb);
                    m_zero <= (r == 32'd0);
                    m_ovf  <= ($signed(pa) - $signed(pb)) != $signed(r) ||
                              ((pa[31] != pb[31]) && (r[31] != pa[31]));
                end else begin
                    rem <= rem - 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("diff", diff, m_diff);
            check("borrow_out", {31'd0, borrow_out}, {31'd0, m_bor});
`ifdef SERIAL_SUB_FLAGS_EN
            check("zero", {31'd0, zero}, {31'd0, m_zero});
            check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
`endif
        end
    end

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end while (!done && cycles < 40);
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, output int cycles);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        wait_done(cycles);
    endtask

    task automatic check_result(input string name, input int cycles, input logic [31:0] ed,
                                input logic eb, input logic ez, input logic eo);
        check({name, "_latency"}, cycles, 33);
        check({name, "_done"}, {31'd0, done}, 32'd1);
        check({name, "_diff"}, diff, ed);
        check({name, "_borrow"}, {31'd0, borrow_out}, {31'd0, eb});
`ifdef SERIAL_SUB_FLAGS_EN
        check({name, "_zero"}, {31'd0, zero}, {31'd0, ez});
        check({name, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
`else
        if (ez === 1'bx || eo === 1'bx) $display("note: flag expectation undefined");
`endif
    endtask

    initial begin
        int cyc;
        int dcount;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", diff, 32'd0);
        check("rst_borrow", {31'd0, borrow_out}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        run_op(32'd5, 32'd3, cyc);
        check_result("5m3", cyc, 32'h00000002, 1'b0, 1'b0, 1'b0);
        run_op(32'd0, 32'd1, cyc);
        check_result("0m1", cyc, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        run_op(32'h1234ABCD, 32'h1234ABCD, cyc);
        check_result("eq", cyc, 32'h00000000, 1'b0, 1'b1, 1'b0);
        run_op(32'h80000000, 32'h00000001, cyc);
        check_result("minm1", cyc, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
        run_op(32'h7FFFFFFF, 32'hFFFFFFFF, cyc);
        check_result("maxmm1", cyc, 32'h80000000, 1'b1, 1'b0, 1'b1);
        run_op(32'hDEADBEEF, 32'h0BADF00D, cyc);
        check_result("mixed", cyc, 32'hD2FFCEE2, 1'b0, 1'b0, 1'b0);

        // start and operand changes during RUN must be ignored
        @(negedge clk);
        a = 32'd10; b = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 32'hFFFF0000; b = 32'h00000123;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("ignore_dones", dcount, 1);
        check("ignore_diff", diff, 32'd6);
        check("ignore_idle", {31'd0, busy}, 32'd0);

        // reset in the middle of RUN aborts without done
        @(negedge clk);
        a = 32'd100; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_diff", diff, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        run_op(32'd100, 32'd1, cyc);
        check_result("after_rst", cyc, 32'd99, 1'b0, 1'b0, 1'b0);

        // back-to-back: start held through the DONE cycle
        run_op(32'd20, 32'd5, cyc);
        check_result("first", cyc, 32'd15, 1'b0, 1'b0, 1'b0);
        a = 32'd7; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_result("second", cyc, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
